// File: rtl/fetch_sequencer.sv
// Run/halt state machine and program counter for the single-cycle core.
// Tracks RUN-state cycles and retired instructions since the last accepted START.
module fetch_sequencer #(
    parameter int PC_W  = 8,
    parameter int OFF_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [PC_W-1:0]  START_ADDR,
    input  logic             HALT,
    input  logic             BRANCH,
    input  logic             BR_TAKEN,
    input  logic [OFF_W-1:0] BR_OFFSET,
    input  logic             STALL,
    output logic [PC_W-1:0]  PC,
    output logic             RUN,
    output logic             DONE,
    output logic [CNT_W-1:0] CYCLE_CNT,
    output logic [CNT_W-1:0] INSN_CNT
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] insn_q, insn_d;
    logic [PC_W-1:0]  br_ext;

    assign br_ext = {{(PC_W-OFF_W){BR_OFFSET[OFF_W-1]}}, BR_OFFSET};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        insn_d  = insn_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                    cyc_d   = '0;
                    insn_d  = '0;
                end
            end
            S_RUN: begin
                cyc_d = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_ONE;
                // Strobes are only looked at once STALL is known low.
                if (!STALL) begin
                    insn_d = (insn_q == CNT_MAX) ? insn_q : insn_q + CNT_ONE;
                    if (HALT) begin
                        state_d = S_DONE;
                    end else if (BRANCH && BR_TAKEN) begin
                        pc_d = pc_q + br_ext;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cyc_q   <= '0;
            insn_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
            insn_q  <= insn_d;
        end
    end

    assign PC        = pc_q;
    assign RUN       = (state_q == S_RUN);
    assign DONE      = (state_q == S_DONE);
    assign CYCLE_CNT = cyc_q;
    assign INSN_CNT  = insn_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: single-instruction vector table plus
// hand-written sequences for runs, stalls, START handling and async reset.
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [7:0]  START_ADDR;
    logic        HALT;
    logic        BRANCH;
    logic        BR_TAKEN;
    logic [5:0]  BR_OFFSET;
    logic        STALL;
    logic [7:0]  PC;
    logic        RUN;
    logic        DONE;
    logic [15:0] CYCLE_CNT;
    logic [15:0] INSN_CNT;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START(START), .START_ADDR(START_ADDR),
        .HALT(HALT), .BRANCH(BRANCH), .BR_TAKEN(BR_TAKEN), .BR_OFFSET(BR_OFFSET),
        .STALL(STALL), .PC(PC), .RUN(RUN), .DONE(DONE),
        .CYCLE_CNT(CYCLE_CNT), .INSN_CNT(INSN_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] addr;
        logic       halt;
        logic       branch;
        logic       taken;
        logic [5:0] off;
        logic [7:0] exp_pc;
        logic       exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] pc, input logic run,
                             input logic done, input logic [15:0] cyc, input logic [15:0] insn);
        $display("%s: PC=%02h RUN=%0d DONE=%0d CYC=%0d INSN=%0d", name, PC, RUN, DONE, CYCLE_CNT, INSN_CNT);
        check({name, ".pc"}, 32'(PC), 32'(pc));
        check({name, ".run"}, 32'(RUN), 32'(run));
        check({name, ".done"}, 32'(DONE), 32'(done));
        check({name, ".cyc"}, 32'(CYCLE_CNT), 32'(cyc));
        check({name, ".insn"}, 32'(INSN_CNT), 32'(insn));
    endtask

    task automatic do_start(input logic [7:0] addr);
        START_ADDR = addr;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h20, 1'b0, 1'b1, 1'b1, 6'h3D, 8'h1D, 1'b0}; // -3 taken
        vecs[1] = '{8'h20, 1'b0, 1'b1, 1'b0, 6'h3D, 8'h21, 1'b0}; // not taken
        vecs[2] = '{8'h02, 1'b0, 1'b1, 1'b1, 6'h3B, 8'hFD, 1'b0}; // -5 wraps below 0
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b0}; // PC+1 wrap
        vecs[4] = '{8'h30, 1'b1, 1'b1, 1'b1, 6'h04, 8'h30, 1'b1}; // HALT beats BRANCH
        vecs[5] = '{8'h7E, 1'b0, 1'b1, 1'b1, 6'h1F, 8'h9D, 1'b0}; // max positive offset
        vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b1, 6'h20, 8'h60, 1'b0}; // max negative offset
        vecs[7] = '{8'h10, 1'b0, 1'b0, 1'b1, 6'h05, 8'h11, 1'b0}; // BR_TAKEN without BRANCH

        RESET = 1'b1; START = 1'b0; START_ADDR = 8'h00; HALT = 1'b0;
        BRANCH = 1'b0; BR_TAKEN = 1'b0; BR_OFFSET = 6'h00; STALL = 1'b0;
        #2;
        check_all("reset", 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        RESET = 1'b0;
        tick();
        check_all("idle_hold", 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);

        // Straight-line run with an ignored START in the middle.
        do_start(8'h10);
        check_all("line_start", 8'h10, 1'b1, 1'b0, 16'd0, 16'd0);
        tick();
        check_all("line_1", 8'h11, 1'b1, 1'b0, 16'd1, 16'd1);
        START_ADDR = 8'h55; START = 1'b1;
        tick();
        START = 1'b0;
        check_all("start_in_run", 8'h12, 1'b1, 1'b0, 16'd2, 16'd2);
        tick();
        check_all("line_3", 8'h13, 1'b1, 1'b0, 16'd3, 16'd3);
        HALT = 1'b1;
        tick();
        HALT = 1'b0;
        check_all("line_halt", 8'h13, 1'b0, 1'b1, 16'd4, 16'd4);
        tick();
        check_all("done_hold", 8'h13, 1'b0, 1'b1, 16'd4, 16'd4);

        do_start(8'h40);
        check_all("restart", 8'h40, 1'b1, 1'b0, 16'd0, 16'd0);
        HALT = 1'b1;
        tick();
        HALT = 1'b0;

        // Stall with HALT and a taken branch held: nothing retires.
        do_start(8'h05);
        STALL = 1'b1; HALT = 1'b1; BRANCH = 1'b1; BR_TAKEN = 1'b1; BR_OFFSET = 6'h07;
        tick();
        check_all("stall_1", 8'h05, 1'b1, 1'b0, 16'd1, 16'd0);
        tick();
        tick();
        check_all("stall_3", 8'h05, 1'b1, 1'b0, 16'd3, 16'd0);
        STALL = 1'b0;
        tick();
        HALT = 1'b0; BRANCH = 1'b0; BR_TAKEN = 1'b0;
        check_all("stall_rel", 8'h05, 1'b0, 1'b1, 16'd4, 16'd1);

        for (int i = 0; i < 8; i++) begin
            do_start(vecs[i].addr);
            check($sformatf("vec%0d.start_pc", i), 32'(PC), 32'(vecs[i].addr));
            HALT = vecs[i].halt; BRANCH = vecs[i].branch;
            BR_TAKEN = vecs[i].taken; BR_OFFSET = vecs[i].off;
            tick();
            HALT = 1'b0; BRANCH = 1'b0; BR_TAKEN = 1'b0;
            check_all($sformatf("vec%0d", i), vecs[i].exp_pc, ~vecs[i].exp_done,
                      vecs[i].exp_done, 16'd1, 16'd1);
            if (!DONE) begin
                HALT = 1'b1;
                tick();
                HALT = 1'b0;
            end
        end

        // Asynchronous reset between edges, mid-run at PC=0x13.
        do_start(8'h10);
        tick(); tick(); tick();
        #3;
        RESET = 1'b1;
        #1;
        check_all("async_rst", 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);
        START_ADDR = 8'h22; START = 1'b1;
        tick();
        START = 1'b0;
        check_all("start_in_rst", 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);
        RESET = 1'b0;
        tick(); tick();
        check_all("post_rst_idle", 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);
        do_start(8'h22);
        check_all("post_rst_start", 8'h22, 1'b1, 1'b0, 16'd0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
